// File: rtl/modport_fifo.sv
// -----------------------------------------------------------------------------
// modport_fifo
//
// Single-clock synchronous FIFO. It sits between a producer agent (winc/wdata)
// and a consumer agent (rinc/rdata). Both sides share the wclk domain.
//
// Handshake: a write is accepted on a rising edge of wclk when winc=1 and
// wfull=0. A read is accepted on a rising edge when rinc=1 and rempty=0.
// Both accept conditions use the flags as they stood before the edge. rdata
// is registered, so the popped word appears after the accepting edge. rdata
// holds its value on every edge that accepts no read.
//
// Parameters:
//   DSIZE     data width in bits
//   ASIZE     address width; the FIFO holds DEPTH = 2**ASIZE entries
//   AF_MARGIN awfull is set when count >= DEPTH-AF_MARGIN
//   AE_MARGIN arempty is set when count <= AE_MARGIN
//
// Ports:
//   wclk       in   sole clock, rising edge
//   wrst       in   asynchronous active-high reset
//   winc       in   write request
//   wdata      in   write data [DSIZE]
//   rinc       in   read request
//   rdata      out  registered read data [DSIZE]
//   wfull      out  count == DEPTH
//   awfull     out  almost full
//   rempty     out  count == 0
//   arempty    out  almost empty
//   woverflow  out  sticky: a write was attempted while full
//                   (present only with FIFO_ERR_FLAGS_EN)
//   runderflow out  sticky: a read was attempted while empty
//                   (present only with FIFO_ERR_FLAGS_EN)
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
// -----------------------------------------------------------------------------
module modport_fifo #(
    parameter int DSIZE     = 32,
    parameter int ASIZE     = 4,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
) (
    input  logic             wclk,
    input  logic             wrst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             wfull,
    output logic             awfull,
    output logic             rempty,
`ifdef FIFO_ERR_FLAGS_EN
    output logic             arempty,
    output logic             woverflow,
    output logic             runderflow
`else
    output logic             arempty
`endif
);

    localparam int DEPTH = 2 ** ASIZE;
    localparam int PW    = ASIZE + 1;

    // Flag thresholds, sized to the pointer width so the compares need no casts.
    localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);
    localparam logic [PW-1:0] AF_CNT   = PW'(DEPTH - AF_MARGIN);
    localparam logic [PW-1:0] AE_CNT   = PW'(AE_MARGIN);

    logic [DSIZE-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    count;
    logic             do_write;
    logic             do_read;

    // The extra top bit of each pointer separates full (difference DEPTH) from
    // empty (difference 0) when the low bits are equal.
    assign count = wptr - rptr;

    assign wfull   = (count == FULL_CNT);
    assign rempty  = (count == '0);
    assign awfull  = (count >= AF_CNT);
    assign arempty = (count <= AE_CNT);

    // Gating uses the flags from before the edge. At full, a simultaneous
    // write is dropped. At empty, a simultaneous read is ignored.
    assign do_write = winc & ~wfull;
    assign do_read  = rinc & ~rempty;

    // Storage is not reset, so no reset term appears in this block.
    always_ff @(posedge wclk) begin
        if (do_write) begin
            mem[wptr[ASIZE-1:0]] <= wdata;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wptr <= '0;
        end else if (do_write) begin
            wptr <= wptr + 1'b1;
        end
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            rptr  <= '0;
            rdata <= '0;
        end else if (do_read) begin
            rptr  <= rptr + 1'b1;
            rdata <= mem[rptr[ASIZE-1:0]];
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // These flags stay set until reset, so a single bad access stays visible.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            woverflow  <= 1'b0;
            runderflow <= 1'b0;
        end else begin
            if (winc && wfull) begin
                woverflow <= 1'b1;
            end
            if (rinc && rempty) begin
                runderflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// -----------------------------------------------------------------------------
// tb_modport_fifo
//
// Directed bench for modport_fifo. Each step drives the inputs and waits for
// one rising edge. The outputs are then sampled 1 time unit later. Every
// expected value in this file is written out by hand.
// -----------------------------------------------------------------------------
module tb_modport_fifo;

    logic        wclk;
    logic        wrst;
    logic        winc;
    logic [31:0] wdata;
    logic        rinc;
    logic [31:0] rdata;
    logic        wfull;
    logic        awfull;
    logic        rempty;
    logic        arempty;
`ifdef FIFO_ERR_FLAGS_EN
    logic        woverflow;
    logic        runderflow;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    modport_fifo dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .winc      (winc),
        .wdata     (wdata),
        .rinc      (rinc),
        .rdata     (rdata),
        .wfull     (wfull),
        .awfull    (awfull),
        .rempty    (rempty),
`ifdef FIFO_ERR_FLAGS_EN
        .arempty   (arempty),
        .woverflow (woverflow),
        .runderflow(runderflow)
`else
        .arempty   (arempty)
`endif
    );

    // clock / reset
    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 unit after the edge.
    task automatic step(input logic w, input logic [31:0] d, input logic r);
        winc  = w;
        wdata = d;
        rinc  = r;
        @(posedge wclk);
        #1;
        winc = 1'b0;
        rinc = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic f, input logic af,
                               input logic e, input logic ae);
        check({tag, "_wfull"},   {31'd0, wfull},   {31'd0, f});
        check({tag, "_awfull"},  {31'd0, awfull},  {31'd0, af});
        check({tag, "_rempty"},  {31'd0, rempty},  {31'd0, e});
        check({tag, "_arempty"}, {31'd0, arempty}, {31'd0, ae});
    endtask

    initial begin
        wrst  = 1'b1;
        winc  = 1'b0;
        rinc  = 1'b0;
        wdata = '0;
        repeat (3) @(posedge wclk);
        #1;
        check_flags("por", 1'b0, 1'b0, 1'b1, 1'b1);
        check("por_rdata", rdata, 32'h0);
        wrst = 1'b0;

        // Write five words and read one, so rdata is non-zero. Then apply
        // reset between two edges.
        for (int i = 1; i <= 5; i++) step(1'b1, 32'(i), 1'b0);
        check_flags("five", 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1);
        check("pre_rst_rdata", rdata, 32'h1);
        #2 wrst = 1'b1;
        #1;
        check_flags("midrst", 1'b0, 1'b0, 1'b1, 1'b1);
        check("midrst_rdata", rdata, 32'h0);
        @(posedge wclk);
        #1 wrst = 1'b0;

        // Fill from empty.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h1000 + 32'(i), 1'b0);
            check_flags($sformatf("fill%0d", i + 1), (i == 15), (i >= 14), 1'b0, (i == 0));
        end
        // Overflow attempt. The write must be dropped.
        step(1'b1, 32'hDEAD, 1'b0);
        check_flags("ovf", 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef FIFO_ERR_FLAGS_EN
        check("woverflow", {31'd0, woverflow}, 32'd1);
        check("runderflow_clr", {31'd0, runderflow}, 32'd0);
`endif

        // Drain. The words must come back in write order.
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 32'h0, 1'b1);
            check($sformatf("drain%0d_rdata", k), rdata, 32'h1000 + 32'(k));
            check_flags($sformatf("drain%0d", k), 1'b0, (k == 0), (k == 15), (k >= 14));
        end
        // Underflow attempt. rdata must hold.
        step(1'b0, 32'h0, 1'b1);
        check("udf_rdata", rdata, 32'h100F);
        check_flags("udf", 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
        check("runderflow", {31'd0, runderflow}, 32'd1);
`endif

        // Wrap: alternate single writes and reads over 40 cycles. This takes
        // the pointers around the buffer more than twice.
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 32'h2000 + 32'(i), 1'b0);
            check_flags($sformatf("wrap%0d_w", i), 1'b0, 1'b0, 1'b0, 1'b1);
            step(1'b0, 32'h0, 1'b1);
            check($sformatf("wrap%0d_rdata", i), rdata, 32'h2000 + 32'(i));
            check_flags($sformatf("wrap%0d_r", i), 1'b0, 1'b0, 1'b1, 1'b1);
        end

        // Simultaneous write and read at full.
        for (int i = 0; i < 16; i++) step(1'b1, 32'h3000 + 32'(i), 1'b0);
        check_flags("full2", 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 32'hBEEF, 1'b1);
        check("simfull_rdata", rdata, 32'h3000);
        check_flags("simfull", 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k < 16; k++) begin
            step(1'b0, 32'h0, 1'b1);
            check($sformatf("simfull_drain%0d", k), rdata, 32'h3000 + 32'(k));
        end
        check_flags("simfull_empty", 1'b0, 1'b0, 1'b1, 1'b1);

        // Simultaneous write and read at empty.
        step(1'b1, 32'hBEEF, 1'b1);
        check("simempty_rdata", rdata, 32'h300F);
        check_flags("simempty", 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        check("simempty_pop", rdata, 32'hBEEF);
        check_flags("simempty_end", 1'b0, 1'b0, 1'b1, 1'b1);

        // Steady state at count=8.
        for (int i = 0; i < 8; i++) step(1'b1, 32'h4000 + 32'(i), 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h4008 + 32'(i), 1'b1);
            check($sformatf("steady%0d_rdata", i), rdata, 32'h4000 + 32'(i));
            check_flags($sformatf("steady%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 32'h0, 1'b1);
            check($sformatf("steady_drain%0d", i), rdata, 32'h400A + 32'(i));
        end
        check_flags("final", 1'b0, 1'b0, 1'b1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
